// File: rtl/pll_lock_ctrl.sv
// PLL lock sequencer: waits for a stable reference period, settles, then asserts lock.
// Define PLL_LOSS_OF_LOCK_EN to drop lock on a period mismatch; otherwise LOCK is sticky.
module pll_lock_ctrl #(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned LOCK_CNT   = 64,
  parameter int unsigned TOL_1000   = 0
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        PWRDWN,
  input  logic [31:0] ref_period_1000,
  output logic        period_stable,
  output logic        gen_rst,
  output logic        locked,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_IDLE    = 3'd1,
    ST_MEASURE = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_LOCK    = 3'd4
  } state_t;

  localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CNT);
  localparam logic [15:0] LOCK_MAX   = 16'(LOCK_CNT);
  localparam logic [32:0] TOL        = 33'(TOL_1000);

  state_t      r_state, w_next;
  logic [7:0]  r_stable_cnt, w_stable_nx;
  logic [15:0] r_lock_cnt, w_lock_nx;
  logic [31:0] r_prev;
  logic        r_period_stable, r_locked, r_gen_rst;

  logic [32:0] w_a, w_b, w_diff;
  logic        w_match;

  // Widened to 33 bits so the absolute difference never wraps.
  assign w_a     = {1'b0, ref_period_1000};
  assign w_b     = {1'b0, r_prev};
  assign w_diff  = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
  assign w_match = (ref_period_1000 != '0) && (r_prev != '0) && (w_diff <= TOL);

  always_comb begin
    w_next      = r_state;
    w_stable_nx = r_stable_cnt;
    w_lock_nx   = r_lock_cnt;
    if (RST) begin
      w_next      = ST_IDLE;
      w_stable_nx = '0;
      w_lock_nx   = '0;
    end else if (PWRDWN) begin
      w_next      = ST_OFF;
      w_stable_nx = '0;
      w_lock_nx   = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_next = ST_IDLE;
        end
        ST_IDLE: begin
          w_next      = ST_MEASURE;
          w_stable_nx = '0;
          w_lock_nx   = '0;
        end
        ST_MEASURE: begin
          if (w_match) begin
            if (r_stable_cnt != STABLE_MAX) w_stable_nx = r_stable_cnt + 8'd1;
            if (w_stable_nx == STABLE_MAX) w_next = ST_SETTLE;
          end else begin
            w_stable_nx = '0;
          end
        end
        ST_SETTLE: begin
          if (!w_match) begin
            w_next      = ST_MEASURE;
            w_stable_nx = '0;
            w_lock_nx   = '0;
          end else begin
            w_lock_nx = r_lock_cnt + 16'd1;
            if (w_lock_nx == LOCK_MAX) w_next = ST_LOCK;
          end
        end
        ST_LOCK: begin
`ifdef PLL_LOSS_OF_LOCK_EN
          if (!w_match) begin
            w_next      = ST_MEASURE;
            w_stable_nx = '0;
            w_lock_nx   = '0;
          end
`else
          w_next = ST_LOCK;
`endif
        end
        default: begin
          w_next      = ST_IDLE;
          w_stable_nx = '0;
          w_lock_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_stable_cnt <= '0;
      r_lock_cnt   <= '0;
      r_prev       <= '0;
    end else begin
      r_state      <= w_next;
      r_stable_cnt <= w_stable_nx;
      r_lock_cnt   <= w_lock_nx;
      if (r_state != ST_OFF && r_state != ST_IDLE) r_prev <= ref_period_1000;
    end
  end

  // Outputs are registered from the next state so they always agree with r_state.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_period_stable <= 1'b0;
      r_locked        <= 1'b0;
      r_gen_rst       <= 1'b1;
    end else begin
      r_period_stable <= (w_next == ST_SETTLE) || (w_next == ST_LOCK);
      r_locked        <= (w_next == ST_LOCK);
      r_gen_rst       <= (w_next == ST_OFF) || (w_next == ST_IDLE) || (w_next == ST_MEASURE);
    end
  end

  assign period_stable = r_period_stable;
  assign locked        = r_locked;
  assign gen_rst       = r_gen_rst;
  assign state         = r_state;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: directed timing scenarios plus random stimulus vs. a behavioural model.
module tb_pll_lock_ctrl;

  localparam int unsigned SC  = 4;
  localparam int unsigned LC  = 64;
  localparam int unsigned TOL = 50;
`ifdef PLL_LOSS_OF_LOCK_EN
  localparam bit LOL = 1'b1;
`else
  localparam bit LOL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pd  = 1'b0;
  logic [31:0] ref_p = 32'd10000;
  logic        ps, grst, lk;
  logic [2:0]  st;

  always #5 clk = ~clk;

  pll_lock_ctrl #(.STABLE_CNT(SC), .LOCK_CNT(LC), .TOL_1000(TOL)) dut (
    .clk(clk), .RST(rst), .PWRDWN(pd), .ref_period_1000(ref_p),
    .period_stable(ps), .gen_rst(grst), .locked(lk), .state(st)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          m_st  = 1;
  int unsigned m_sc  = 0;
  int unsigned m_lc  = 0;
  longint      m_prev = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: state numbers follow the externally visible encoding OFF..LOCK = 0..4.
  task automatic model_step();
    longint d;
    bit     match;
    d = longint'(ref_p) - m_prev;
    if (d < 0) d = -d;
    match = (ref_p != 0) && (m_prev != 0) && (d <= longint'(TOL));
    if (rst) m_prev = 0;
    else if (m_st >= 2) m_prev = longint'(ref_p);
    if (rst) begin
      m_st = 1; m_sc = 0; m_lc = 0;
    end else if (pd) begin
      m_st = 0;
    end else if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1) begin
      m_st = 2; m_sc = 0; m_lc = 0;
    end else if (m_st == 2) begin
      if (!match) m_sc = 0;
      else if (m_sc < SC) m_sc++;
      if (m_sc == SC) m_st = 3;
    end else if (m_st == 3) begin
      if (!match) begin
        m_st = 2; m_sc = 0; m_lc = 0;
      end else begin
        m_lc++;
        if (m_lc == LC) m_st = 4;
      end
    end else if (LOL && !match) begin
      m_st = 2; m_sc = 0; m_lc = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("state",         32'(st),   32'(m_st));
    check_eq("period_stable", 32'(ps),   32'(m_st >= 3));
    check_eq("locked",        32'(lk),   32'(m_st == 4));
    check_eq("gen_rst",       32'(grst), 32'(m_st <= 2));
  endtask

  task automatic drive(input logic r, input logic p, input logic [31:0] v);
    rst = r; pd = p; ref_p = v;
  endtask

  task automatic do_reset(input logic [31:0] v);
    drive(1'b1, 1'b0, v); tick(); tick();
  endtask

  // Edge indices (1-based, from the first tick of the call) where outputs first change.
  task automatic lock_run(input logic [31:0] per, output int ps_e, output int lk_e, output int g_e);
    ps_e = -1; lk_e = -1; g_e = -1;
    for (int i = 1; i <= 200; i++) begin
      drive(1'b0, 1'b0, per);
      tick();
      if (ps_e < 0 && ps) ps_e = i;
      if (g_e < 0 && !grst) g_e = i;
      if (lk_e < 0 && lk) begin
        lk_e = i;
        break;
      end
    end
  endtask

  int          e_ps, e_lk, e_g;
  logic [31:0] cur;
  int          pd_hold;

  initial begin
    // Reset state
    do_reset(32'd10000);
    check_eq("reset_state", 32'(st), 32'd1);
    check_eq("reset_gen_rst", 32'(grst), 32'd1);

    // Nominal lock timing from reset release
    lock_run(32'd10000, e_ps, e_lk, e_g);
    check_eq("ps_rise_edge", 32'(e_ps), 32'd6);
    check_eq("lock_rise_edge", 32'(e_lk), 32'd70);
    check_eq("gen_rst_fall_edge", 32'(e_g), 32'd6);

    // Tolerance boundary
    do_reset(32'd10000);
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b0, (i % 2 != 0) ? 32'd10050 : 32'd10000);
      tick();
    end
    check_eq("tol50_locked", 32'(lk), 32'd1);
    do_reset(32'd10000);
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b0, (i % 2 != 0) ? 32'd10051 : 32'd10000);
      tick();
    end
    check_eq("tol51_state", 32'(st), 32'd2);
    check_eq("tol51_locked", 32'(lk), 32'd0);

    // Settle abort after 30 settle cycles, then relock
    do_reset(32'd10000);
    for (int i = 0; i < 36; i++) begin
      drive(1'b0, 1'b0, 32'd10000);
      tick();
    end
    check_eq("settle_before_abort", 32'(st), 32'd3);
    drive(1'b0, 1'b0, 32'd12000);
    tick();
    check_eq("abort_state", 32'(st), 32'd2);
    check_eq("abort_ps", 32'(ps), 32'd0);
    lock_run(32'd12000, e_ps, e_lk, e_g);
    check_eq("relock_ps_edge", 32'(e_ps), 32'd4);
    check_eq("relock_lock_edge", 32'(e_lk), 32'd68);

    // Period step while locked
    do_reset(32'd10000);
    lock_run(32'd10000, e_ps, e_lk, e_g);
    drive(1'b0, 1'b0, 32'd8000);
    tick();
    check_eq("step_locked", 32'(lk), LOL ? 32'd0 : 32'd1);
    for (int i = 0; i < 5; i++) tick();

    // Power-down pulse during LOCK, then relock; RST dominates PWRDWN
    do_reset(32'd10000);
    lock_run(32'd10000, e_ps, e_lk, e_g);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'd10000);
      tick();
    end
    check_eq("pd_state", 32'(st), 32'd0);
    check_eq("pd_ps", 32'(ps), 32'd0);
    check_eq("pd_locked", 32'(lk), 32'd0);
    check_eq("pd_gen_rst", 32'(grst), 32'd1);
    drive(1'b0, 1'b0, 32'd10000);
    tick();
    check_eq("pd_release_state", 32'(st), 32'd1);
    lock_run(32'd10000, e_ps, e_lk, e_g);
    check_eq("pd_relocked", 32'(e_lk > 0), 32'd1);
    drive(1'b1, 1'b1, 32'd10000);
    tick();
    check_eq("rst_pd_state", 32'(st), 32'd1);

    // Zero period never qualifies
    do_reset(32'd0);
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 1'b0, 32'd0);
      tick();
    end
    check_eq("zero_state", 32'(st), 32'd2);
    check_eq("zero_locked", 32'(lk), 32'd0);

    // Random stimulus
    do_reset(32'd10000);
    cur = 32'd10000;
    pd_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 3))
          0: cur = 32'd0;
          1: cur = 32'd10000 + 32'($urandom_range(0, 120));
          2: cur = 32'd8000;
          default: cur = cur + 32'($urandom_range(0, 60));
        endcase
      end
      if (pd_hold == 0 && $urandom_range(0, 199) == 0) pd_hold = int'($urandom_range(1, 4));
      drive(($urandom_range(0, 399) == 0), (pd_hold > 0), cur);
      if (pd_hold > 0) pd_hold--;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
